// File: rtl/cic_pkg.sv
// Shared CIC constants and helpers, used by the decimator and the compensator.
package cic_pkg;

  localparam int CicMaxOrder = 7;

  // Worst-case register growth of an N-stage, unit-delay CIC at rate R.
  function automatic int CicBitGrowth(input int order, input int rate);
    return order * $clog2(rate);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: registered wrap-around accumulator with enable.
module cic_integrator_stage #(
  parameter int Width = 29
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] acc_q
);

  logic [Width-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = acc_q + din;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (differential delay 1) with a single-word output register.
// Define CIC_DECIMATOR_OVERRUN_EN to get the sticky `overrun` port.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int InputLengthBits  = 17,
  parameter int OutputLengthBits = 29,
  parameter int DecimationRate   = 16,
  parameter int FilterOrder      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [InputLengthBits-1:0]  in,
  input  logic                        in_valid,
  output logic [OutputLengthBits-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef CIC_DECIMATOR_OVERRUN_EN
  ,
  output logic                        overrun
`endif
);

  localparam int OW = OutputLengthBits;
  localparam int IW = InputLengthBits;
  localparam int CW = $clog2(DecimationRate);
  localparam logic [CW-1:0] CntLast = CW'(DecimationRate - 1);

  if (OutputLengthBits < InputLengthBits + CicBitGrowth(FilterOrder, DecimationRate)
      || FilterOrder > CicMaxOrder || FilterOrder < 1
      || DecimationRate < 2 || DecimationRate > 1024) begin : g_bad_cfg
    $error("cic_decimator: unsupported configuration (width, order or rate)");
  end

  logic [FilterOrder-1:0][OW-1:0] integ_in;
  logic [FilterOrder-1:0][OW-1:0] integ_q;
  logic [FilterOrder-1:0][OW-1:0] dly_q, dly_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [OW-1:0]                  out_q, out_d;
  logic                           out_valid_q, out_valid_d;
  logic [OW-1:0]                  comb_x;
  logic                           dec;

  assign dec = in_valid && (cnt_q == CntLast);

  // Stage 0 sees the sign-extended sample; later stages see the previous register.
  always_comb begin
    integ_in    = '0;
    integ_in[0] = {{(OW-IW){in[IW-1]}}, in};
    for (int k = 1; k < FilterOrder; k++) integ_in[k] = integ_q[k-1];
  end

  for (genvar k = 0; k < FilterOrder; k++) begin : g_integ
    cic_integrator_stage #(.Width(OW)) u_integ (
      .clk   (clk),
      .rst   (rst),
      .en    (in_valid),
      .din   (integ_in[k]),
      .acc_q (integ_q[k])
    );
  end

  // Comb chain runs only at the decimated rate; the delays capture each stage's input.
  always_comb begin
    comb_x = integ_q[FilterOrder-1];
    dly_d  = dly_q;
    for (int k = 0; k < FilterOrder; k++) begin
      if (dec) dly_d[k] = comb_x;
      comb_x = comb_x - dly_q[k];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) cnt_d = dec ? '0 : cnt_q + 1'b1;
    out_d       = dec ? comb_x : out_q;
    out_valid_d = out_valid_q;
    if (dec)                           out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dly_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef CIC_DECIMATOR_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A new word landing on an untaken one loses the old word.
  assign overrun_d = overrun_q | (dec && out_valid_q && !out_ready);

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at default parameters (R=16, N=3, gain 4096).
module tb_cic_decimator;

  localparam int IW = 17;
  localparam int OW = 29;
  localparam int R  = 16;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] in_s = '0;
  logic [OW-1:0] out_s;
  logic          out_valid;
`ifdef CIC_DECIMATOR_OVERRUN_EN
  logic          overrun;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cic_decimator #(
    .InputLengthBits (IW),
    .OutputLengthBits(OW),
    .DecimationRate  (R),
    .FilterOrder     (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_s),
    .in_valid (in_valid),
    .out      (out_s),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef CIC_DECIMATOR_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  // Drive one cycle; outputs are observed 1 ns after the edge.
  task automatic step(input logic v, input logic [IW-1:0] x, input logic rdy, input logic r);
    rst = r; in_valid = v; in_s = x; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 17'd5, 1'b1, 1'b1);
    total++; if (out_s !== '0) begin bad++; $display("FAIL reset_out got=%0d want=0", out_s); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
`ifdef CIC_DECIMATOR_OVERRUN_EN
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
`endif
  endtask

  // Step response of a unit DC input: third differences of C(16m-1,3).
  task automatic test_dc();
    logic [OW-1:0] exp_tab [6];
    int nout;
    exp_tab = '{29'd455, 29'd3130, 29'd4095, 29'd4096, 29'd4096, 29'd4096};
    nout = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int n = 1; n <= 96; n++) begin
      step(1'b1, 17'd1, 1'b1, 1'b0);
      total++;
      if (out_valid !== (n % R == 0)) begin
        bad++; $display("FAIL dc_valid n=%0d got=%b want=%b", n, out_valid, (n % R == 0));
      end
      if (n % R == 0) begin
        total++;
        if (out_s !== exp_tab[nout]) begin
          bad++; $display("FAIL dc_out idx=%0d got=%0d want=%0d", nout, out_s, exp_tab[nout]);
        end
        nout++;
      end
    end
  endtask

  task automatic test_neg_full_scale();
    int nout;
    nout = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int n = 1; n <= 96; n++) begin
      step(1'b1, 17'h10000, 1'b1, 1'b0);
      if (n % R == 0) begin
        nout++;
        if (nout > N) begin
          total++;
          if (out_valid !== 1'b1 || out_s !== 29'h1000_0000) begin
            bad++; $display("FAIL negfs_out idx=%0d got=%h valid=%b want=%h", nout, out_s, out_valid, 29'h1000_0000);
          end
        end
      end
    end
  endtask

  // Each decimated phase of the R^N impulse response sums to R^(N-1); all R phases give R^N.
  task automatic test_impulse();
    int grand, sum, nz, v;
    grand = 0;
    for (int p = 0; p < R; p++) begin
      sum = 0; nz = 0;
      step(1'b0, '0, 1'b1, 1'b1);
      for (int n = 0; n < 96; n++) begin
        step(1'b1, (n == p) ? 17'd1 : 17'd0, 1'b1, 1'b0);
        if (out_valid) begin
          v = int'($signed(out_s));
          sum += v;
          if (v != 0) nz++;
        end
      end
      total++; if (sum != 256) begin bad++; $display("FAIL impulse_phase_sum p=%0d got=%0d want=256", p, sum); end
      total++; if (nz > N + 1) begin bad++; $display("FAIL impulse_nonzero p=%0d got=%0d want<=%0d", p, nz, N + 1); end
      grand += sum;
    end
    total++; if (grand != 4096) begin bad++; $display("FAIL impulse_total got=%0d want=4096", grand); end
  endtask

  task automatic test_sparse();
    int acc, nout, cyc;
    logic v, exp_v;
    acc = 0; nout = 0; cyc = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    while (acc < 128 && cyc < 3000) begin
      v = ($urandom_range(0, 2) == 0);
      step(v, 17'd5, 1'b1, 1'b0);
      cyc++;
      if (v) acc++;
      exp_v = v && (acc % R == 0);
      total++;
      if (out_valid !== exp_v) begin bad++; $display("FAIL sparse_valid acc=%0d got=%b want=%b", acc, out_valid, exp_v); end
      if (exp_v) begin
        nout++;
        if (nout > N) begin
          total++;
          if (out_s !== 29'd20480) begin bad++; $display("FAIL sparse_out idx=%0d got=%0d want=20480", nout, out_s); end
        end
      end
    end
    total++; if (acc < 128) begin bad++; $display("FAIL sparse_timeout accepted=%0d want=128", acc); end
    total++; if (nout != 8) begin bad++; $display("FAIL sparse_count got=%0d want=8", nout); end
  endtask

  task automatic test_backpressure();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      step(1'b1, 17'd1, 1'b0, 1'b0);
      if (n == 16 || n == 31) begin
        total++;
        if (out_valid !== 1'b1 || out_s !== 29'd455) begin
          bad++; $display("FAIL bp_hold n=%0d got=%0d valid=%b want=455", n, out_s, out_valid);
        end
      end
`ifdef CIC_DECIMATOR_OVERRUN_EN
      if (n == 31) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_overrun_early got=%b want=0", overrun); end
      end
`endif
      if (n == 32 || n == 40) begin
        total++;
        if (out_valid !== 1'b1 || out_s !== 29'd3130) begin
          bad++; $display("FAIL bp_newest n=%0d got=%0d valid=%b want=3130", n, out_s, out_valid);
        end
      end
    end
`ifdef CIC_DECIMATOR_OVERRUN_EN
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
`ifdef CIC_DECIMATOR_OVERRUN_EN
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky got=%b want=1", overrun); end
`endif
    for (int n = 41; n <= 63; n++) begin
      step(1'b1, 17'd1, 1'b0, 1'b0);
      if (n == 48) begin
        total++;
        if (out_valid !== 1'b1 || out_s !== 29'd4095) begin
          bad++; $display("FAIL bp_third got=%0d valid=%b want=4095", out_s, out_valid);
        end
      end
    end
    step(1'b1, 17'd1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_s !== 29'd4096) begin
      bad++; $display("FAIL bp_coincide got=%0d valid=%b want=4096/1", out_s, out_valid);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_final_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    logic early;
    early = 1'b0;
    for (int n = 0; n < 7; n++) step(1'b1, 17'd3, 1'b1, 1'b0);
    step(1'b1, 17'd3, 1'b1, 1'b1);
    total++; if (out_s !== '0) begin bad++; $display("FAIL midrst_out got=%0d want=0", out_s); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
`ifdef CIC_DECIMATOR_OVERRUN_EN
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun got=%b want=0", overrun); end
`endif
    for (int n = 1; n <= 16; n++) begin
      step(1'b1, 17'd3, 1'b1, 1'b0);
      if (n < 16 && out_valid) early = 1'b1;
    end
    total++; if (early) begin bad++; $display("FAIL midrst_early got=1 want=0"); end
    total++;
    if (out_valid !== 1'b1 || out_s !== 29'd1365) begin
      bad++; $display("FAIL midrst_first got=%0d valid=%b want=1365/1", out_s, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_neg_full_scale();
    test_impulse();
    test_sparse();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
